// File: rtl/fft_frame_seq_pkg.sv
// Shared types and width helper for the FFT frame sequencer.
package fft_frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Counter width for n states; never below one bit so CORE_LAT of 0 or 1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_seq_if.sv
// Control/status bundle between a frame controller (master) and the sequencer (slave).
interface fft_frame_seq_if #(
    parameter int N_POINTS = 16
);
    import fft_frame_pkg::*;

    localparam int CNT_W = cnt_width(N_POINTS);

    logic             start;
    logic             cont;
    logic             stop;
    logic             sipo_en;
    logic             piso_load;
    logic             piso_en;
    logic             out_valid;
    logic [CNT_W-1:0] sample_idx;
    logic             frame_done;
    logic             busy;

    modport master (
        output start, cont, stop,
        input  sipo_en, piso_load, piso_en, out_valid, sample_idx, frame_done, busy
    );

    modport slave (
        input  start, cont, stop,
        output sipo_en, piso_load, piso_en, out_valid, sample_idx, frame_done, busy
    );

endinterface

// File: rtl/fft_frame_seq_mod_counter.sv
// Clearable up-counter with terminal-count flag against a runtime limit; exposes its next value.
module fft_mod_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count_nxt,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Next count: clear beats enable, otherwise hold.
    always_comb begin
        if (clr) begin
            count_nxt = {W{1'b0}};
        end else if (en) begin
            count_nxt = count_r + W'(1'b1);
        end else begin
            count_nxt = count_r;
        end
    end

    assign tc = (count_r == limit);

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_nxt;
        end
    end

endmodule

// File: rtl/fft_frame_seq.sv
// N-point FFT frame sequencer: FILL -> WAIT -> LOAD -> DRAIN clock enables for SIPO/PISO.
// Define FFT_FRAME_SEQ_OVERLAP_EN to overlap the next frame's fill with the current drain in continuous mode.
module fft_frame_seq
    import fft_frame_pkg::*;
#(
    parameter int  N_POINTS = 16,
    parameter int  CORE_LAT = 2,
    localparam int CNT_W    = cnt_width(N_POINTS)
) (
    input  logic           clk,
    input  logic           rst_n,
    fft_frame_seq_if.slave bus
);

    localparam int               WAIT_W    = cnt_width(CORE_LAT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N_POINTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((CORE_LAT > 0) ? CORE_LAT - 1 : 0);
    localparam state_t            POST_FILL = (CORE_LAT > 0) ? WAIT : LOAD;
`ifdef FFT_FRAME_SEQ_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    state_t            state_r, state_nxt;
    logic              cnt_clr, cnt_en, cnt_tc;
    logic              wait_clr, wait_en, wait_tc;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [WAIT_W-1:0] wait_nxt_unused;
    logic              ovl_r, ovl_nxt;
    logic              sipo_nxt;

    logic              sipo_en_r, piso_load_r, piso_en_r, frame_done_r, busy_r;
    logic [CNT_W-1:0]  sample_idx_r;

    fft_mod_counter #(.W(CNT_W)) u_sample_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .limit     (CNT_LAST),
        .count_nxt (cnt_nxt),
        .tc        (cnt_tc)
    );

    fft_mod_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (wait_clr),
        .en        (wait_en),
        .limit     (WAIT_LAST),
        .count_nxt (wait_nxt_unused),
        .tc        (wait_tc)
    );

    // Next-state and counter control; ovl_r tracks whether every drain cycle also filled the next frame.
    always_comb begin
        state_nxt = state_r;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        wait_clr  = 1'b0;
        wait_en   = 1'b0;
        ovl_nxt   = ovl_r;
        if (bus.stop) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
            wait_clr  = 1'b1;
            ovl_nxt   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt = FILL;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                FILL: begin
                    if (cnt_tc) begin
                        state_nxt = POST_FILL;
                        cnt_clr   = 1'b1;
                        wait_clr  = 1'b1;
                    end else begin
                        cnt_en    = 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_tc) begin
                        state_nxt = LOAD;
                        wait_clr  = 1'b1;
                    end else begin
                        wait_en   = 1'b1;
                    end
                end
                LOAD: begin
                    state_nxt = DRAIN;
                    cnt_clr   = 1'b1;
                    ovl_nxt   = OVERLAP && bus.cont;
                end
                DRAIN: begin
                    if (cnt_tc) begin
                        cnt_clr  = 1'b1;
                        wait_clr = 1'b1;
                        ovl_nxt  = 1'b0;
                        if (bus.cont || bus.start) begin
                            state_nxt = ovl_r ? POST_FILL : FILL;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_en  = 1'b1;
                        ovl_nxt = ovl_r && bus.cont;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                    wait_clr  = 1'b1;
                    ovl_nxt   = 1'b0;
                end
            endcase
        end
        sipo_nxt = (state_nxt == FILL) || ((state_nxt == DRAIN) && ovl_nxt);
    end

    // State and output registers; outputs are the Moore decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ovl_r        <= 1'b0;
            sipo_en_r    <= 1'b0;
            piso_load_r  <= 1'b0;
            piso_en_r    <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
            sample_idx_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt;
            ovl_r        <= ovl_nxt;
            sipo_en_r    <= sipo_nxt;
            piso_load_r  <= (state_nxt == LOAD);
            piso_en_r    <= (state_nxt == DRAIN);
            frame_done_r <= (state_nxt == DRAIN) && (cnt_nxt == CNT_LAST);
            busy_r       <= (state_nxt != IDLE);
            sample_idx_r <= ((state_nxt == FILL) || (state_nxt == DRAIN)) ? cnt_nxt : {CNT_W{1'b0}};
        end
    end

    assign bus.sipo_en    = sipo_en_r;
    assign bus.piso_load  = piso_load_r;
    assign bus.piso_en    = piso_en_r;
    assign bus.out_valid  = piso_en_r;
    assign bus.frame_done = frame_done_r;
    assign bus.busy       = busy_r;
    assign bus.sample_idx = sample_idx_r;

endmodule
